uart_loopback_echo: RTL and testbench

- UART echo block: receives 8N1 bytes on i_rx and retransmits each byte unchanged on o_tx.
- Contains a receiver, a small byte FIFO and a transmitter, all driven by one system clock.
- Used as a board-level link check: a host sends bytes and expects the identical bytes back.
- Bit timing is set by a clock divisor; no separate baud clock exists.

---
 rtl/uart_loopback_echo.sv | 209 ++++++++++++++++++++
 tb/tb_uart_loopback_echo.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_loopback_echo.sv
// UART 8N1 echo: rx -> byte FIFO -> tx, all on clk; bit time = DIVISOR clocks.
// Ports: clk, i_reset_n (async low), i_rx, o_tx, o_overflow (sticky), o_frame_err (pulse).
// Optional macro UART_LOOPBACK_FRAME_CHECK_EN: drop bytes with a bad stop bit and pulse o_frame_err.
module uart_loopback_echo #(
  parameter int DIVISOR      = 9,
  parameter int SAMPLE_PHASE = DIVISOR / 2,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic clk,
  input  logic i_reset_n,
  input  logic i_rx,
  output logic o_tx,
  output logic o_overflow,
  output logic o_frame_err
);

  localparam int CW   = $clog2(DIVISOR);
  localparam int AW   = $clog2(FIFO_DEPTH);
  localparam int SPM1 = (SAMPLE_PHASE > 0) ? SAMPLE_PHASE - 1 : 0;

  localparam logic [CW-1:0] DIV_LAST = CW'(DIVISOR - 1);
  localparam logic [CW-1:0] SP_LAST  = CW'(SPM1);

  // ---------------- rx synchronizer + edge detect ----------------
  logic rx_s1;
  logic rx_s2;
  logic rx_prev;
  logic rx_fall;

  always_ff @(posedge clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      rx_s1   <= 1'b1;
      rx_s2   <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_s1   <= i_rx;
      rx_s2   <= rx_s1;
      rx_prev <= rx_s2;
    end
  end

  // a fall needs a high first, so a low stop bit
  // cannot retrigger until the line recovers
  assign rx_fall = rx_prev & ~rx_s2;

  // ---------------- rx fsm ----------------
  typedef enum logic [1:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP
  } rx_state_t;

  rx_state_t     rx_state;
  logic [CW-1:0] rx_cnt;
  logic [2:0]    rx_bit;
  logic [7:0]    rx_shift;
  logic          rx_valid;
  logic          frame_err_q;

  always_ff @(posedge clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      rx_state    <= RX_IDLE;
      rx_cnt      <= '0;
      rx_bit      <= '0;
      rx_shift    <= '0;
      rx_valid    <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      rx_valid    <= 1'b0;
      frame_err_q <= 1'b0;
      unique case (rx_state)
        RX_IDLE: begin
          if (rx_fall) begin
            rx_state <= RX_START;
            rx_cnt   <= '0;
          end
        end
        RX_START: begin
          if (rx_cnt >= SP_LAST) begin
            rx_cnt   <= '0;
            rx_bit   <= '0;
            rx_state <= rx_s2 ? RX_IDLE : RX_DATA;
          end else begin
            rx_cnt <= rx_cnt + 1'b1;
          end
        end
        RX_DATA: begin
          if (rx_cnt == DIV_LAST) begin
            rx_cnt   <= '0;
            rx_shift <= {rx_s2, rx_shift[7:1]};
            rx_bit   <= rx_bit + 1'b1;
            if (rx_bit == 3'd7)
              rx_state <= RX_STOP;
          end else begin
            rx_cnt <= rx_cnt + 1'b1;
          end
        end
        RX_STOP: begin
          if (rx_cnt == DIV_LAST) begin
            rx_cnt   <= '0;
            rx_state <= RX_IDLE;
`ifdef UART_LOOPBACK_FRAME_CHECK_EN
            rx_valid    <= rx_s2;
            frame_err_q <= ~rx_s2;
`else
            rx_valid    <= 1'b1;
`endif
          end else begin
            rx_cnt <= rx_cnt + 1'b1;
          end
        end
        default: rx_state <= RX_IDLE;
      endcase
    end
  end

  assign o_frame_err = frame_err_q;

  // ---------------- byte fifo ----------------
  logic [7:0] mem [FIFO_DEPTH];
  logic [AW:0] wr_ptr;
  logic [AW:0] rd_ptr;
  logic        empty;
  logic        full;
  logic        push;
  logic        pop;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) &&
                 (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  // a pop in the same cycle frees the slot being written
  assign push  = rx_valid && (!full || pop);

  always_ff @(posedge clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      o_overflow <= 1'b0;
    end else begin
      if (push)
        wr_ptr <= wr_ptr + 1'b1;
      if (pop)
        rd_ptr <= rd_ptr + 1'b1;
      if (rx_valid && full && !pop)
        o_overflow <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push)
      mem[wr_ptr[AW-1:0]] <= rx_shift;
  end

  // ---------------- tx fsm ----------------
  typedef enum logic {
    TX_IDLE,
    TX_SEND
  } tx_state_t;

  tx_state_t     tx_state;
  logic [CW-1:0] tx_cnt;
  logic [3:0]    tx_bit;
  logic [8:0]    tx_shift;
  logic          tx_end;

  // bit 0 = start, 1..8 = data, 9 = stop
  assign tx_end = (tx_state == TX_SEND) &&
                  (tx_cnt == DIV_LAST) &&
                  (tx_bit == 4'd9);
  assign pop    = !empty && ((tx_state == TX_IDLE) || tx_end);

  always_ff @(posedge clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      tx_state <= TX_IDLE;
      tx_cnt   <= '0;
      tx_bit   <= '0;
      tx_shift <= '1;
      o_tx     <= 1'b1;
    end else if (pop) begin
      tx_state <= TX_SEND;
      tx_cnt   <= '0;
      tx_bit   <= '0;
      tx_shift <= {1'b1, mem[rd_ptr[AW-1:0]]};
      o_tx     <= 1'b0;
    end else begin
      unique case (tx_state)
        TX_IDLE: o_tx <= 1'b1;
        TX_SEND: begin
          if (tx_cnt == DIV_LAST) begin
            tx_cnt <= '0;
            if (tx_bit == 4'd9) begin
              tx_state <= TX_IDLE;
              o_tx     <= 1'b1;
            end else begin
              o_tx     <= tx_shift[0];
              tx_shift <= {1'b1, tx_shift[8:1]};
              tx_bit   <= tx_bit + 1'b1;
            end
          end else begin
            tx_cnt <= tx_cnt + 1'b1;
          end
        end
        default: tx_state <= TX_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_loopback_echo.sv
// Bench for uart_loopback_echo: directed frames, table vectors,
// back-to-back, glitch, overflow and reset corner cases.
module tb_uart_loopback_echo;

  localparam int D  = 9;
  localparam int SP = 4;

`ifdef UART_LOOPBACK_FRAME_CHECK_EN
  localparam int FC = 1;
`else
  localparam int FC = 0;
`endif

  logic clk = 1'b0;
  logic i_reset_n;
  logic i_rx;
  logic o_tx;
  logic o_overflow;
  logic o_frame_err;

  uart_loopback_echo dut (
    .clk        (clk),
    .i_reset_n  (i_reset_n),
    .i_rx       (i_rx),
    .o_tx       (o_tx),
    .o_overflow (o_overflow),
    .o_frame_err(o_frame_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // bench-side receiver on o_tx
  logic [7:0] q_data[$];
  int         q_start[$];
  int         stop_bad   = 0;
  int         tx_low_cnt = 0;
  int         ferr_cnt   = 0;
  logic       mon_act    = 1'b0;
  int         mon_st     = 0;
  int         mk;
  int         midx;
  logic [7:0] mon_sh     = '0;

  always @(negedge clk) begin
    if (!i_reset_n) begin
      mon_act = 1'b0;
    end else begin
      if (!o_tx) tx_low_cnt++;
      if (o_frame_err) ferr_cnt++;
      if (!mon_act) begin
        if (!o_tx) begin
          mon_act = 1'b1;
          mon_st  = cyc;
        end
      end else begin
        mk = cyc - mon_st;
        if (mk >= SP && ((mk - SP) % D) == 0) begin
          midx = (mk - SP) / D;
          if (midx >= 1 && midx <= 8) mon_sh[midx-1] = o_tx;
          if (midx == 9) begin
            if (!o_tx) stop_bad++;
            q_data.push_back(mon_sh);
            q_start.push_back(mon_st);
            mon_act = 1'b0;
          end
        end
      end
    end
  end

  task automatic send_frame(input logic [7:0] b, input logic stop,
                            input int stop_len, output int t0);
    t0   = cyc;
    i_rx = 1'b0;
    repeat (D) @(posedge clk);
    #1;
    for (int i = 0; i < 8; i++) begin
      i_rx = b[i];
      repeat (D) @(posedge clk);
      #1;
    end
    i_rx = stop;
    repeat (stop_len) @(posedge clk);
    #1;
    i_rx = 1'b1;
  endtask

  task automatic idle(input int n);
    i_rx = 1'b1;
    repeat (n) @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic [7:0] data;
    logic       stop;
    int         exp_echo;
    int         exp_ferr;
  } vec_t;

  vec_t vecs[6];
  int   t0;
  int   tfirst;
  logic [7:0] b2b[4];
  logic [7:0] sent[120];
  int   j;
  int   ok;
  int   found;

  initial begin
    vecs[0] = '{8'hA5, 1'b1, 1, 0};
    vecs[1] = '{8'h3C, 1'b0, 1 - FC, FC};
    vecs[2] = '{8'h42, 1'b1, 1, 0};
    vecs[3] = '{8'h01, 1'b1, 1, 0};
    vecs[4] = '{8'hFE, 1'b1, 1, 0};
    vecs[5] = '{8'h5A, 1'b1, 1, 0};
    b2b[0] = 8'h00;
    b2b[1] = 8'hFF;
    b2b[2] = 8'h55;
    b2b[3] = 8'h80;

    // reset with the line toggling
    i_reset_n = 1'b0;
    i_rx      = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      #1;
      i_rx = ~i_rx;
    end
    @(negedge clk);
    chk("rst_tx", o_tx, 1);
    chk("rst_ovf", o_overflow, 0);
    chk("rst_ferr", o_frame_err, 0);
    @(posedge clk);
    #1;
    i_rx      = 1'b1;
    i_reset_n = 1'b1;
    idle(10);

    // table of single frames
    for (int v = 0; v < 6; v++) begin
      q_data.delete();
      q_start.delete();
      ferr_cnt = 0;
      send_frame(vecs[v].data, vecs[v].stop, D, t0);
      idle(200);
      chk($sformatf("v%0d_cnt", v), q_data.size(), vecs[v].exp_echo);
      if (q_data.size() > 0 && vecs[v].exp_echo == 1) begin
        chk($sformatf("v%0d_data", v), q_data[0], vecs[v].data);
        chk($sformatf("v%0d_start", v), q_start[0], t0 + 10 * D);
      end
      chk($sformatf("v%0d_ferr", v), ferr_cnt, vecs[v].exp_ferr);
    end

    // back-to-back with no idle gaps
    q_data.delete();
    q_start.delete();
    for (int i = 0; i < 4; i++) begin
      send_frame(b2b[i], 1'b1, D, t0);
      if (i == 0) tfirst = t0;
    end
    idle(500);
    chk("b2b_cnt", q_data.size(), 4);
    if (q_data.size() == 4) begin
      chk("b2b_first", q_start[0], tfirst + 10 * D);
      for (int i = 0; i < 4; i++) begin
        chk($sformatf("b2b_d%0d", i), q_data[i], b2b[i]);
        chk($sformatf("b2b_t%0d", i), q_start[i], q_start[0] + 10 * D * i);
      end
    end
    chk("b2b_ovf", o_overflow, 0);

    // glitch: 2 cycles low
    q_data.delete();
    tx_low_cnt = 0;
    i_rx = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    idle(200);
    chk("glitch_low", tx_low_cnt, 0);
    chk("glitch_cnt", q_data.size(), 0);

    // overflow: shortened stop bits
    q_data.delete();
    q_start.delete();
    for (int i = 0; i < 120; i++) begin
      sent[i] = 8'((i * 13 + 7) & 255);
      send_frame(sent[i], 1'b1, SP + 1, t0);
    end
    idle(700);
    chk("ovf_set", o_overflow, 1);
    chk("ovf_dropped", (q_data.size() < 120 && q_data.size() >= 5), 1);
    if (q_data.size() >= 5) begin
      for (int i = 0; i < 5; i++)
        chk($sformatf("ovf_d%0d", i), q_data[i], sent[i]);
    end
    j  = 0;
    ok = 1;
    foreach (q_data[i]) begin
      while (j < 120 && sent[j] != q_data[i]) j++;
      if (j >= 120) ok = 0;
      else j++;
    end
    chk("ovf_order", ok, 1);
    idle(100);
    chk("ovf_sticky", o_overflow, 1);
    chk("stop_bits", stop_bad, 0);

    // reset in the middle of a tx frame
    q_data.delete();
    send_frame(8'h96, 1'b1, D, t0);
    found = 0;
    for (int i = 0; i < 200 && found == 0; i++) begin
      @(negedge clk);
      if (!o_tx) found = 1;
    end
    chk("midtx_seen", found, 1);
    repeat (30) @(posedge clk);
    #2;
    i_reset_n = 1'b0;
    #1;
    chk("midtx_tx", o_tx, 1);
    chk("midtx_ovf", o_overflow, 0);
    repeat (3) @(posedge clk);
    #1;
    i_reset_n  = 1'b1;
    tx_low_cnt = 0;
    q_data.delete();
    idle(200);
    chk("post_rst_low", tx_low_cnt, 0);
    chk("post_rst_cnt", q_data.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
